exe_stage: RTL and testbench
============================

// Module: exe_stage
// PURPOSE
//  Execute stage of the 5-stage ARM-subset pipeline; consumes the ID->EXE pipeline register outputs.
//  Builds Val2 (rotated imm / shifted Rm / mem offset), runs the ALU, computes the branch target.
//  Owns the NZCV status register and the EXE->MEM pipeline register feeding the memory stage.
// PARAMETERS
//  (none) -- datapath fixed at 32 bits, register index 4 bits, status 4 bits {N,Z,C,V}.
// PORTS
//  clk               in   1   clock, all state updates on rising edge
//  rst               in   1   reset, synchronous, active-high
//  freeze            in   1   memory-stage stall: hold all state, suppress branch_taken
//  wb_en_in          in   1   writeback enable from ID->EXE register
//  mem_r_en_in       in   1   load instruction
//  mem_w_en_in       in   1   store instruction
//  b_in              in   1   branch (condition already resolved in ID)
//  s_in              in   1   update status register
//  exe_cmd_in        in   4   ALU command (encoding below)
//  pc_in             in   32  PC+4 of the instruction
//  val_rn_in         in   32  Rn value
//  val_rm_in         in   32  Rm value (also store data)
//  imm_in            in   1   1 = rotated immediate operand
//  status_in         in   4   {N,Z,C,V} travelling with the instruction; C used by ADC/SBC
//  shift_operand_in  in   12  shifter operand field
//  signed_imm_24_in  in   24  branch offset (words)
//  dest_in           in   4   destination register index
//  branch_taken      out  1   comb: b_in & ~freeze
//  branch_addr       out  32  comb: pc_in + {{6{imm24[23]}}, imm24, 2'b00}
//  status_reg        out  4   registered {N,Z,C,V}
//  wb_en             out  1   registered
//  mem_r_en          out  1   registered
//  mem_w_en          out  1   registered
//  alu_res           out  32  registered ALU result / memory address
//  st_val            out  32  registered val_rm_in (store data)
//  dest              out  4   registered destination index
// BEHAVIOUR
//  Reset (rst=1 at edge): every registered output and status_reg <= 0; wins over freeze.
//  Latency: 1 cycle input -> registered outputs; branch_taken/branch_addr combinational, same cycle.
//  freeze=1: EXE->MEM register and status_reg hold; branch_taken forced 0.
//  Val2 select, priority order:
//   mem_r_en_in|mem_w_en_in : {20'b0, so[11:0]} (zero-extended offset)
//   imm_in=1                : {24'b0, so[7:0]} ROR (2*so[11:8])
//   else                    : Rm shifted by so[11:7], type so[6:5] 00 LSL,01 LSR,10 ASR,11 ROR;
//                             amount 0 -> Rm unchanged for all types; so[4] ignored.
//  ALU (exe_cmd_in): 0001 MOV=Val2; 1001 MVN=~Val2; 0010 ADD=Rn+Val2; 0011 ADC=Rn+Val2+C;
//   0100 SUB/CMP=Rn-Val2; 0101 SBC=Rn-Val2-!C; 0110 AND/TST; 0111 ORR; 1000 EOR; others -> 0.
//  Flags: N=res[31], Z=(res==0) always. ADD/ADC: C=carry-out of 33-bit sum. SUB/SBC: C=NOT borrow
//   (carry-out of Rn+~Val2+cin). V=signed overflow for arith; logic/MOV/MVN: C,V = status_in C,V.
//  status_reg <= flags only when s_in & ~freeze & ~rst; otherwise holds.
//  Bubbles (all enables 0, s_in=0) pass through with no side effect.
//  All arithmetic mod 2^32; branch_addr wraps silently.
// TESTING
//  rst=1 one cycle after random traffic -> all registered outputs and status_reg = 0 next cycle.
//  ADD s=1, Rn=0x7FFFFFFF, imm=1, so=12'h001 -> alu_res=0x80000000, status_reg=4'b1001.
//  CMP(0100) s=1 wb_en=0, Rn=5, Rm=5, so=0 -> alu_res=0, status_reg=4'b0110; s=0 next -> holds.
//  MOV imm so=12'h4FF -> 0xFF000000; MOV Rm=0x80000000 so ASR#4 (so=12'h240) -> 0xF8000000.
//  LDR Rn=0x100 so=12'h00C mem_r_en=1 -> alu_res=0x10C, mem_r_en=1; STR: st_val=val_rm_in.
//  B pc_in=0x20 imm24=0xFFFFFE -> branch_taken=1, branch_addr=0x18; same with freeze=1 -> taken=0, regs hold.

Source files
------------

// File: rtl/exe_stage_if.sv
// Execute-stage bus: ID->EXE pipeline register outputs in, EXE->MEM register
// and branch redirect out. The stage uses the slave modport; the driver of
// the ID->EXE side (and consumer of the outputs) uses master.
interface exe_stage_if;
  // memory-stage stall
  logic        freeze;

  // ID->EXE side
  logic        wb_en_in;
  logic        mem_r_en_in;
  logic        mem_w_en_in;
  logic        b_in;
  logic        s_in;
  logic [3:0]  exe_cmd_in;
  logic [31:0] pc_in;
  logic [31:0] val_rn_in;
  logic [31:0] val_rm_in;
  logic        imm_in;
  logic [3:0]  status_in;
  logic [11:0] shift_operand_in;
  logic [23:0] signed_imm_24_in;
  logic [3:0]  dest_in;

  // branch redirect (combinational)
  logic        branch_taken;
  logic [31:0] branch_addr;

  // status register and EXE->MEM side (registered)
  logic [3:0]  status_reg;
  logic        wb_en;
  logic        mem_r_en;
  logic        mem_w_en;
  logic [31:0] alu_res;
  logic [31:0] st_val;
  logic [3:0]  dest;

  modport slave (
    input  freeze, wb_en_in, mem_r_en_in, mem_w_en_in, b_in, s_in, exe_cmd_in,
           pc_in, val_rn_in, val_rm_in, imm_in, status_in, shift_operand_in,
           signed_imm_24_in, dest_in,
    output branch_taken, branch_addr, status_reg, wb_en, mem_r_en, mem_w_en,
           alu_res, st_val, dest
  );

  modport master (
    output freeze, wb_en_in, mem_r_en_in, mem_w_en_in, b_in, s_in, exe_cmd_in,
           pc_in, val_rn_in, val_rm_in, imm_in, status_in, shift_operand_in,
           signed_imm_24_in, dest_in,
    input  branch_taken, branch_addr, status_reg, wb_en, mem_r_en, mem_w_en,
           alu_res, st_val, dest
  );
endinterface

// File: rtl/exe_stage.sv
// Execute stage of the ARM-subset pipeline: Val2 generation, ALU with NZCV
// flags, branch target, NZCV status register and EXE->MEM pipeline register.
module exe_stage (
  input  logic       clk,
  input  logic       rst,
  exe_stage_if.slave bus
);

  typedef enum logic [3:0] {
    CMD_MOV = 4'b0001,
    CMD_ADD = 4'b0010,
    CMD_ADC = 4'b0011,
    CMD_SUB = 4'b0100,
    CMD_SBC = 4'b0101,
    CMD_AND = 4'b0110,
    CMD_ORR = 4'b0111,
    CMD_EOR = 4'b1000,
    CMD_MVN = 4'b1001
  } alu_cmd_e;

  typedef enum logic [1:0] {
    SH_LSL = 2'b00,
    SH_LSR = 2'b01,
    SH_ASR = 2'b10,
    SH_ROR = 2'b11
  } shift_e;

  alu_cmd_e    cmd;
  shift_e      sh_type;
  logic [11:0] so;
  logic [31:0] rn;
  logic [31:0] rm;
  logic        c_in;

  logic [4:0]  imm_rot;
  logic [4:0]  sh_amt;
  logic [63:0] imm_dbl;
  logic [63:0] rm_dbl;
  logic [31:0] val2;

  logic [32:0] sum;
  logic [31:0] res;
  logic        c_out;
  logic        v_out;
  logic [3:0]  flags;

  assign cmd     = alu_cmd_e'(bus.exe_cmd_in);
  assign so      = bus.shift_operand_in;
  assign sh_type = shift_e'(so[6:5]);
  assign rn      = bus.val_rn_in;
  assign rm      = bus.val_rm_in;
  assign c_in    = bus.status_in[1];

  // Branch redirect is resolved upstream; a stall suppresses it.
  assign bus.branch_taken = bus.b_in & ~bus.freeze;
  assign bus.branch_addr  = bus.pc_in + {{6{bus.signed_imm_24_in[23]}}, bus.signed_imm_24_in, 2'b00};

  // Val2 selection: memory offset, then rotated immediate, then shifted Rm.
  // Rotations shift a doubled copy right and keep the low word, so a zero
  // amount naturally returns the operand unchanged.
  always_comb begin
    imm_rot = {so[11:8], 1'b0};
    sh_amt  = so[11:7];
    imm_dbl = {2{24'b0, so[7:0]}} >> imm_rot;
    rm_dbl  = {rm, rm} >> sh_amt;
    val2    = '0;
    if (bus.mem_r_en_in || bus.mem_w_en_in) begin
      val2 = {20'b0, so};
    end else if (bus.imm_in) begin
      val2 = imm_dbl[31:0];
    end else begin
      case (sh_type)
        SH_LSL:  val2 = rm << sh_amt;
        SH_LSR:  val2 = rm >> sh_amt;
        SH_ASR:  val2 = 32'($signed(rm) >>> sh_amt);
        SH_ROR:  val2 = rm_dbl[31:0];
        default: val2 = rm;
      endcase
    end
  end

  // ALU and flag generation. Subtraction is Rn + ~Val2 + cin so that the
  // carry-out is the ARM "not borrow" directly.
  always_comb begin
    sum   = '0;
    res   = '0;
    c_out = bus.status_in[1];
    v_out = bus.status_in[0];
    case (cmd)
      CMD_MOV: res = val2;
      CMD_MVN: res = ~val2;
      CMD_ADD, CMD_ADC: begin
        sum   = {1'b0, rn} + {1'b0, val2} + {32'b0, (cmd == CMD_ADC) & c_in};
        res   = sum[31:0];
        c_out = sum[32];
        v_out = (rn[31] == val2[31]) && (res[31] != rn[31]);
      end
      CMD_SUB, CMD_SBC: begin
        sum   = {1'b0, rn} + {1'b0, ~val2} + {32'b0, (cmd == CMD_SBC) ? c_in : 1'b1};
        res   = sum[31:0];
        c_out = sum[32];
        v_out = (rn[31] != val2[31]) && (res[31] != rn[31]);
      end
      CMD_AND: res = rn & val2;
      CMD_ORR: res = rn | val2;
      CMD_EOR: res = rn ^ val2;
      default: res = '0;
    endcase
    flags = {res[31], (res == '0), c_out, v_out};
  end

  // EXE->MEM pipeline register; reset wins over freeze.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.wb_en    <= 1'b0;
      bus.mem_r_en <= 1'b0;
      bus.mem_w_en <= 1'b0;
      bus.alu_res  <= '0;
      bus.st_val   <= '0;
      bus.dest     <= '0;
    end else if (!bus.freeze) begin
      bus.wb_en    <= bus.wb_en_in;
      bus.mem_r_en <= bus.mem_r_en_in;
      bus.mem_w_en <= bus.mem_w_en_in;
      bus.alu_res  <= res;
      bus.st_val   <= rm;
      bus.dest     <= bus.dest_in;
    end
  end

  // NZCV status register, written only by flag-setting instructions.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.status_reg <= '0;
    end else if (bus.s_in && !bus.freeze) begin
      bus.status_reg <= flags;
    end
  end

endmodule

// File: tb/tb_exe_stage.sv
// Self-checking bench for exe_stage: a behavioural model computes the next
// EXE->MEM/status contents each cycle into a scoreboard queue, popped and
// compared after the clock edge. Branch outputs are checked combinationally.
module tb_exe_stage;

  logic clk = 1'b0;
  logic rst;
  exe_stage_if bus ();

  exe_stage dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        wb;
    logic        mr;
    logic        mw;
    logic [31:0] alu;
    logic [31:0] st;
    logic [3:0]  dest;
    logic [3:0]  status;
  } exp_t;

  exp_t sb_q[$];
  exp_t mdl;

  int unsigned checks   = 0;
  int unsigned failures = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ror_bits(input logic [31:0] x, input int unsigned n);
    logic [31:0] r;
    r = x;
    for (int unsigned i = 0; i < n; i++) r = {r[0], r[31:1]};
    return r;
  endfunction

  function automatic logic [31:0] asr_bits(input logic [31:0] x, input int unsigned n);
    logic [31:0] r;
    r = x;
    for (int unsigned i = 0; i < n; i++) r = {r[31], r[31:1]};
    return r;
  endfunction

  function automatic logic [31:0] model_val2();
    logic [11:0] so;
    int unsigned amt;
    so  = bus.shift_operand_in;
    amt = int'(so[11:7]);
    if (bus.mem_r_en_in || bus.mem_w_en_in) return 32'(so);
    if (bus.imm_in) return ror_bits(32'(so[7:0]), 2 * int'(so[11:8]));
    case (so[6:5])
      2'b00:   return bus.val_rm_in << amt;
      2'b01:   return bus.val_rm_in >> amt;
      2'b10:   return asr_bits(bus.val_rm_in, amt);
      default: return ror_bits(bus.val_rm_in, amt);
    endcase
  endfunction

  // Returns {flags, result} as a 36-bit value.
  function automatic logic [35:0] model_alu();
    logic [31:0] rn, v, res;
    logic [63:0] u;
    longint      sres;
    logic        c, ov, cin;
    rn  = bus.val_rn_in;
    v   = model_val2();
    cin = bus.status_in[1];
    c   = bus.status_in[1];
    ov  = bus.status_in[0];
    res = 32'h0;
    case (bus.exe_cmd_in)
      4'b0001: res = v;
      4'b1001: res = ~v;
      4'b0010, 4'b0011: begin
        u    = 64'(rn) + 64'(v) + ((bus.exe_cmd_in == 4'b0011) ? 64'(cin) : 64'd0);
        sres = longint'($signed(rn)) + longint'($signed(v)) +
               ((bus.exe_cmd_in == 4'b0011) ? longint'(cin) : 64'sd0);
        res  = u[31:0];
        c    = u[32];
        ov   = (sres > 64'sd2147483647) || (sres < -64'sd2147483648);
      end
      4'b0100, 4'b0101: begin
        logic borrow;
        borrow = (bus.exe_cmd_in == 4'b0101) ? ~cin : 1'b0;
        res  = rn - v - 32'(borrow);
        c    = (64'(rn) >= 64'(v) + 64'(borrow));
        sres = longint'($signed(rn)) - longint'($signed(v)) - longint'(borrow);
        ov   = (sres > 64'sd2147483647) || (sres < -64'sd2147483648);
      end
      4'b0110: res = rn & v;
      4'b0111: res = rn | v;
      4'b1000: res = rn ^ v;
      default: res = 32'h0;
    endcase
    return {res[31], res == 32'h0, c, ov, res};
  endfunction

  task automatic step();
    exp_t        e;
    logic [35:0] a;
    #1;
    check_eq("branch_taken", 32'(bus.branch_taken), 32'(bus.b_in & ~bus.freeze));
    check_eq("branch_addr", bus.branch_addr,
             bus.pc_in + 32'(4 * int'($signed(bus.signed_imm_24_in))));
    a = model_alu();
    if (rst) begin
      mdl = '0;
    end else if (!bus.freeze) begin
      mdl.wb   = bus.wb_en_in;
      mdl.mr   = bus.mem_r_en_in;
      mdl.mw   = bus.mem_w_en_in;
      mdl.alu  = a[31:0];
      mdl.st   = bus.val_rm_in;
      mdl.dest = bus.dest_in;
      if (bus.s_in) mdl.status = a[35:32];
    end
    sb_q.push_back(mdl);
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      check_eq("scoreboard_empty", 32'd1, 32'd0);
    end else begin
      e = sb_q.pop_front();
      check_eq("status_reg", 32'(bus.status_reg), 32'(e.status));
      check_eq("wb_en", 32'(bus.wb_en), 32'(e.wb));
      check_eq("mem_r_en", 32'(bus.mem_r_en), 32'(e.mr));
      check_eq("mem_w_en", 32'(bus.mem_w_en), 32'(e.mw));
      check_eq("alu_res", bus.alu_res, e.alu);
      check_eq("st_val", bus.st_val, e.st);
      check_eq("dest", 32'(bus.dest), 32'(e.dest));
    end
  endtask

  task automatic idle_inputs();
    bus.freeze           = 1'b0;
    bus.wb_en_in         = 1'b0;
    bus.mem_r_en_in      = 1'b0;
    bus.mem_w_en_in      = 1'b0;
    bus.b_in             = 1'b0;
    bus.s_in             = 1'b0;
    bus.exe_cmd_in       = 4'h0;
    bus.pc_in            = 32'h0;
    bus.val_rn_in        = 32'h0;
    bus.val_rm_in        = 32'h0;
    bus.imm_in           = 1'b0;
    bus.status_in        = 4'h0;
    bus.shift_operand_in = 12'h0;
    bus.signed_imm_24_in = 24'h0;
    bus.dest_in          = 4'h0;
  endtask

  task automatic random_inputs();
    bus.freeze           = ($urandom_range(0, 7) == 0);
    bus.wb_en_in         = 1'($urandom);
    bus.mem_r_en_in      = ($urandom_range(0, 5) == 0);
    bus.mem_w_en_in      = ($urandom_range(0, 5) == 0);
    bus.b_in             = 1'($urandom);
    bus.s_in             = 1'($urandom);
    bus.exe_cmd_in       = 4'($urandom);
    bus.pc_in            = $urandom;
    bus.val_rn_in        = ($urandom_range(0, 3) == 0) ? 32'h7FFF_FFFF : $urandom;
    bus.val_rm_in        = $urandom;
    bus.imm_in           = 1'($urandom);
    bus.status_in        = 4'($urandom);
    bus.shift_operand_in = 12'($urandom);
    bus.signed_imm_24_in = 24'($urandom);
    bus.dest_in          = 4'($urandom);
  endtask

  initial begin
    mdl = '0;
    idle_inputs();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;

    // ADD with immediate 1 overflowing into the sign bit
    bus.exe_cmd_in = 4'b0010; bus.s_in = 1'b1; bus.wb_en_in = 1'b1; bus.dest_in = 4'd3;
    bus.val_rn_in = 32'h7FFF_FFFF; bus.imm_in = 1'b1; bus.shift_operand_in = 12'h001;
    step();
    check_eq("add_ovf_res", bus.alu_res, 32'h8000_0000);
    check_eq("add_ovf_nzcv", 32'(bus.status_reg), 32'h9);

    // CMP equal operands, then a non-flag-setting instruction keeps NZCV
    idle_inputs();
    bus.exe_cmd_in = 4'b0100; bus.s_in = 1'b1;
    bus.val_rn_in = 32'd5; bus.val_rm_in = 32'd5;
    step();
    check_eq("cmp_res", bus.alu_res, 32'h0);
    check_eq("cmp_nzcv", 32'(bus.status_reg), 32'h6);
    bus.s_in = 1'b0; bus.val_rn_in = 32'd1;
    step();
    check_eq("cmp_hold_nzcv", 32'(bus.status_reg), 32'h6);

    // MOV rotated immediate and MOV Rm ASR #4
    idle_inputs();
    bus.exe_cmd_in = 4'b0001; bus.imm_in = 1'b1; bus.shift_operand_in = 12'h4FF;
    step();
    check_eq("mov_imm_ror", bus.alu_res, 32'hFF00_0000);
    bus.imm_in = 1'b0; bus.val_rm_in = 32'h8000_0000; bus.shift_operand_in = 12'h240;
    step();
    check_eq("mov_asr4", bus.alu_res, 32'hF800_0000);

    // LDR and STR address generation
    idle_inputs();
    bus.exe_cmd_in = 4'b0010; bus.mem_r_en_in = 1'b1; bus.wb_en_in = 1'b1;
    bus.val_rn_in = 32'h100; bus.shift_operand_in = 12'h00C; bus.imm_in = 1'b1;
    step();
    check_eq("ldr_addr", bus.alu_res, 32'h10C);
    check_eq("ldr_mem_r", 32'(bus.mem_r_en), 32'h1);
    bus.mem_r_en_in = 1'b0; bus.mem_w_en_in = 1'b1; bus.wb_en_in = 1'b0;
    bus.val_rm_in = 32'hCAFE_F00D;
    step();
    check_eq("str_data", bus.st_val, 32'hCAFE_F00D);

    // Branch, then the same branch under freeze
    idle_inputs();
    bus.b_in = 1'b1; bus.pc_in = 32'h20; bus.signed_imm_24_in = 24'hFFFFFE;
    #1;
    check_eq("b_taken", 32'(bus.branch_taken), 32'h1);
    check_eq("b_addr", bus.branch_addr, 32'h18);
    step();
    bus.freeze = 1'b1; bus.s_in = 1'b1; bus.wb_en_in = 1'b1; bus.exe_cmd_in = 4'b0111;
    bus.val_rn_in = 32'hFFFF_FFFF; bus.dest_in = 4'hA;
    #1;
    check_eq("b_frozen_taken", 32'(bus.branch_taken), 32'h0);
    step();

    // random traffic with occasional stalls
    for (int i = 0; i < 300; i++) begin
      random_inputs();
      step();
    end

    // reset after random traffic, with freeze and flag-setting active
    random_inputs();
    bus.freeze = 1'b1; bus.s_in = 1'b1;
    rst = 1'b1;
    step();
    check_eq("rst_status", 32'(bus.status_reg), 32'h0);
    check_eq("rst_alu", bus.alu_res, 32'h0);
    rst = 1'b0;
    idle_inputs();
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
